sram_arbiter: RTL and testbench

Two-master, one-slave arbiter between the CPU core's instruction-fetch and data-access request ports and the single shared synchronous SRAM port. Sits directly downstream of the core's inst/data SRAM interfaces. Converts them to a req/addr_ok/data_ok handshake with one outstanding access at a time, fixed data-over-instruction priority, and a parameterised memory read latency.

---
 rtl/sram_arbiter.sv | 105 ++++++++++
 tb/tb_sram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-master (fetch/data) to one synchronous SRAM port arbiter.
// Only one access is outstanding at a time. Data requests take priority over fetch.
module sram_arbiter #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       done;
    logic       can_accept;
    logic       acc_i;
    logic       acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        mem_en       = 1'b0;
        mem_wen      = '0;
        mem_addr     = '0;
        mem_wdata    = '0;

        // Completion cycle doubles as an acceptance slot, giving zero-gap back-to-back access.
        done       = (state != IDLE) && (cnt == '0);
        can_accept = !rst && ((state == IDLE) || done);
        acc_d      = can_accept && data_req;
        acc_i      = can_accept && inst_req && !data_req;

        if (done && state == BUSY_I) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_rdata;
        end
        if (done && state == BUSY_D) begin
            data_data_ok = 1'b1;
            data_rdata   = mem_rdata;
        end

        if (acc_d) begin
            data_addr_ok = 1'b1;
            mem_en       = 1'b1;
            mem_wen      = data_wen;
            mem_addr     = data_addr;
            mem_wdata    = data_wdata;
            state_nxt    = BUSY_D;
            cnt_nxt      = CNT_LOAD;
        end else if (acc_i) begin
            inst_addr_ok = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = inst_addr;
            state_nxt    = BUSY_I;
            cnt_nxt      = CNT_LOAD;
        end else if (done) begin
            state_nxt = IDLE;
        end else if (state != IDLE) begin
            cnt_nxt = cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboarded bench for sram_arbiter: index 0 runs MEM_LATENCY=1, index 1 runs MEM_LATENCY=3.
module tb_sram_arbiter;

    localparam int unsigned LAT [2] = '{1, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          [2];
    logic        inst_req     [2];
    logic [31:0] inst_addr    [2];
    logic        inst_addr_ok [2];
    logic        inst_data_ok [2];
    logic [31:0] inst_rdata   [2];
    logic        data_req     [2];
    logic [3:0]  data_wen     [2];
    logic [31:0] data_addr    [2];
    logic [31:0] data_wdata   [2];
    logic        data_addr_ok [2];
    logic        data_data_ok [2];
    logic [31:0] data_rdata   [2];
    logic        mem_en       [2];
    logic [3:0]  mem_wen      [2];
    logic [31:0] mem_addr     [2];
    logic [31:0] mem_wdata    [2];
    logic [31:0] mem_rdata    [2];

    sram_arbiter #(.MEM_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst[0]),
        .inst_req(inst_req[0]), .inst_addr(inst_addr[0]),
        .inst_addr_ok(inst_addr_ok[0]), .inst_data_ok(inst_data_ok[0]), .inst_rdata(inst_rdata[0]),
        .data_req(data_req[0]), .data_wen(data_wen[0]), .data_addr(data_addr[0]), .data_wdata(data_wdata[0]),
        .data_addr_ok(data_addr_ok[0]), .data_data_ok(data_data_ok[0]), .data_rdata(data_rdata[0]),
        .mem_en(mem_en[0]), .mem_wen(mem_wen[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    sram_arbiter #(.MEM_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst[1]),
        .inst_req(inst_req[1]), .inst_addr(inst_addr[1]),
        .inst_addr_ok(inst_addr_ok[1]), .inst_data_ok(inst_data_ok[1]), .inst_rdata(inst_rdata[1]),
        .data_req(data_req[1]), .data_wen(data_wen[1]), .data_addr(data_addr[1]), .data_wdata(data_wdata[1]),
        .data_addr_ok(data_addr_ok[1]), .data_data_ok(data_data_ok[1]), .data_rdata(data_rdata[1]),
        .mem_en(mem_en[1]), .mem_wen(mem_wen[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h2402_0101;
    endfunction

    // SRAM model: read data appears LAT cycles after the mem_en cycle
    logic        pv [2][8];
    logic [31:0] pa [2][8];

    initial begin
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 8; s++) begin
                pv[k][s] = 1'b0;
                pa[k][s] = '0;
            end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pv[k][0] <= mem_en[k] && (mem_wen[k] == 4'b0000);
            pa[k][0] <= mem_addr[k];
            for (int s = 1; s < 8; s++) begin
                pv[k][s] <= pv[k][s-1];
                pa[k][s] <= pa[k][s-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++)
            mem_rdata[k] = pv[k][LAT[k]-1] ? mem_fn(pa[k][LAT[k]-1]) : 32'hBAD0_0000;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          dut;
        bit          is_d;
        bit          has_rd;
        logic [31:0] rd;
        int          due;
    } exp_t;

    exp_t sb[$];

    task automatic pop_check(input int k, input bit is_d, input logic [31:0] rd);
        int   idx[$];
        exp_t e;
        idx = sb.find_first_index(x) with (x.dut == k);
        if (idx.size() == 0) begin
            check("dok_unexpected", 1, 0);
        end else begin
            e = sb[idx[0]];
            sb.delete(idx[0]);
            check("dok_master", is_d, e.is_d);
            check("dok_cycle", cyc, e.due);
            if (e.has_rd) check("dok_rdata", rd, e.rd);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                check("rst_outs_a", {inst_addr_ok[k], inst_data_ok[k], inst_rdata[k],
                                     data_addr_ok[k], data_data_ok[k], data_rdata[k]}, 0);
                check("rst_outs_b", {mem_en[k], mem_wen[k], mem_addr[k], mem_wdata[k]}, 0);
            end else begin
                check("both_dok", {inst_data_ok[k], data_data_ok[k]} == 2'b11, 0);
                check("both_aok", {inst_addr_ok[k], data_addr_ok[k]} == 2'b11, 0);
                if (!inst_data_ok[k]) check("irdata_zero", inst_rdata[k], 0);
                if (!data_data_ok[k]) check("drdata_zero", data_rdata[k], 0);
                if (!mem_en[k]) check("mem_idle_zero", {mem_wen[k], mem_addr[k], mem_wdata[k]}, 0);
                if (inst_data_ok[k]) pop_check(k, 1'b0, inst_rdata[k]);
                if (data_data_ok[k]) pop_check(k, 1'b1, data_rdata[k]);
                if (data_addr_ok[k]) begin
                    check("d_mem_drive", {mem_en[k], mem_wen[k], mem_addr[k], mem_wdata[k]},
                          {1'b1, data_wen[k], data_addr[k], data_wdata[k]});
                    sb.push_back('{k, 1'b1, data_wen[k] == 4'b0000, mem_fn(data_addr[k]), cyc + int'(LAT[k])});
                end else if (inst_addr_ok[k]) begin
                    check("i_mem_drive", {mem_en[k], mem_wen[k], mem_addr[k], mem_wdata[k]},
                          {1'b1, 4'b0000, inst_addr[k], 32'h0});
                    sb.push_back('{k, 1'b0, 1'b1, mem_fn(inst_addr[k]), cyc + int'(LAT[k])});
                end
            end
        end
    end

    task automatic drive_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_traffic(input int k, input int ncyc);
        logic ia = 1'b0;
        logic da = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            drive_tick();
            if (!inst_req[k] || ia) begin
                inst_req[k]  = 1'($urandom_range(0, 1));
                inst_addr[k] = $urandom & 32'hFFFF_FFFC;
            end
            if (!data_req[k] || da) begin
                data_req[k]   = ($urandom_range(0, 2) == 0);
                data_wen[k]   = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15));
                data_addr[k]  = $urandom & 32'hFFFF_FFFC;
                data_wdata[k] = $urandom;
            end
            @(negedge clk);
            ia = inst_addr_ok[k];
            da = data_addr_ok[k];
        end
        drive_tick();
        inst_req[k] = 1'b0;
        data_req[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_acc;
        int n_dok;
        int n_men;
        bit acc;

        for (int k = 0; k < 2; k++) begin
            rst[k]        = 1'b1;
            inst_req[k]   = 1'b0;
            inst_addr[k]  = '0;
            data_req[k]   = 1'b0;
            data_wen[k]   = '0;
            data_addr[k]  = '0;
            data_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check("idle_after_rst", {inst_addr_ok[k], inst_data_ok[k], data_addr_ok[k],
                                     data_data_ok[k], mem_en[k], mem_addr[k]}, 0);

        // L=1 fetch
        drive_tick();
        inst_req[0]  = 1'b1;
        inst_addr[0] = 32'h0000_0100;
        @(negedge clk);
        check("t1_iaok", inst_addr_ok[0], 1);
        check("t1_mem", {mem_en[0], mem_addr[0]}, {1'b1, 32'h0000_0100});
        drive_tick();
        inst_req[0] = 1'b0;
        @(negedge clk);
        check("t1_idok", inst_data_ok[0], 1);
        check("t1_irdata", inst_rdata[0], 32'h2402_0001);

        // L=1 simultaneous data and fetch
        drive_tick();
        data_req[0]  = 1'b1;
        data_wen[0]  = 4'b0000;
        data_addr[0] = 32'h8000_0010;
        inst_req[0]  = 1'b1;
        inst_addr[0] = 32'h0000_0104;
        @(negedge clk);
        check("t2_daok", data_addr_ok[0], 1);
        check("t2_iaok_lose", inst_addr_ok[0], 0);
        drive_tick();
        data_req[0] = 1'b0;
        @(negedge clk);
        check("t2_ddok", data_data_ok[0], 1);
        check("t2_drdata", data_rdata[0], 32'hA402_0111);
        check("t2_iaok", inst_addr_ok[0], 1);
        drive_tick();
        inst_req[0] = 1'b0;
        @(negedge clk);
        check("t2_idok", inst_data_ok[0], 1);
        check("t2_irdata", inst_rdata[0], 32'h2402_0005);

        // L=1 partial store
        drive_tick();
        data_req[0]   = 1'b1;
        data_wen[0]   = 4'b0011;
        data_addr[0]  = 32'h0000_0020;
        data_wdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t3_daok", data_addr_ok[0], 1);
        check("t3_mem", {mem_en[0], mem_wen[0], mem_addr[0], mem_wdata[0]},
              {1'b1, 4'b0011, 32'h0000_0020, 32'hDEAD_BEEF});
        drive_tick();
        data_req[0] = 1'b0;
        data_wen[0] = 4'b0000;
        @(negedge clk);
        check("t3_ddok", data_data_ok[0], 1);
        check("t3_no_inst", {inst_addr_ok[0], inst_data_ok[0]}, 0);

        // L=3 continuous fetch stream
        n_acc = 0;
        n_dok = 0;
        n_men = 0;
        drive_tick();
        inst_req[1]  = 1'b1;
        inst_addr[1] = 32'h0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            acc = inst_addr_ok[1];
            if (inst_data_ok[1]) begin
                check("t4_dok_cyc", c, 3 * (n_dok + 1));
                n_dok++;
            end
            if (mem_en[1]) n_men++;
            if (acc) begin
                check("t4_acc_cyc", c, 3 * n_acc);
                n_acc++;
            end
            drive_tick();
            if (acc) begin
                if (n_acc == 3) inst_req[1] = 1'b0;
                else inst_addr[1] = inst_addr[1] + 32'd4;
            end
        end
        check("t4_acc_n", n_acc, 3);
        check("t4_dok_n", n_dok, 3);
        check("t4_men_n", n_men, 3);

        // L=3 reset during an outstanding fetch
        inst_req[1]  = 1'b1;
        inst_addr[1] = 32'h0000_0040;
        @(negedge clk);
        check("t5_iaok", inst_addr_ok[1], 1);
        drive_tick();
        rst[1]       = 1'b1;
        inst_addr[1] = 32'h0000_0080;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].dut == 1) sb.delete(i);
        @(negedge clk);
        check("t5_rst_iaok", inst_addr_ok[1], 0);
        drive_tick();
        @(negedge clk);
        check("t5_rst_men", mem_en[1], 0);
        drive_tick();
        rst[1] = 1'b0;
        @(negedge clk);
        check("t5_no_stale_dok", inst_data_ok[1], 0);
        check("t5_reaccept", inst_addr_ok[1], 1);
        drive_tick();
        inst_req[1] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("t5_dok_timing", inst_data_ok[1], c == 3);
            if (c == 3) check("t5_irdata", inst_rdata[1], 32'h2402_0181);
            if (c < 3) drive_tick();
        end

        fork
            rand_traffic(0, 150);
            rand_traffic(1, 150);
        join

        repeat (12) @(posedge clk);
        @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
